smart_counter: RTL and testbench
================================

SMART_COUNTER -- requirements
Module: smart_counter

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the counter and load-value width in bits (legal range 2..32).
REQ-002: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: enable  input  1  SHALL request a +1 increment when high.
REQ-005: load  input  1  SHALL request a parallel load of load_val when high.
REQ-006: load_val  input  WIDTH  SHALL be the value captured on a load.
REQ-007: count  output  WIDTH  SHALL be the registered counter value.
REQ-008: at_max  output  1  SHALL be high combinationally whenever count equals all-ones.
REQ-009: wrap  output  1  SHALL be a registered one-cycle pulse marking an increment from all-ones to zero.

Function
REQ-010: On each rising clk edge with rst_n high, if load is 1, count SHALL take load_val on that edge (latency 1 clock).
REQ-011: If load is 0 and enable is 1, count SHALL become count+1 modulo 2^WIDTH on that edge.
REQ-012: If load and enable are both 0, count SHALL hold its value.
REQ-013: When load and enable are both high, load SHALL win and no increment SHALL occur that cycle.
REQ-014: Increment from all-ones SHALL wrap to zero with no saturation.
REQ-015: wrap SHALL be 1 for exactly the cycle after an increment that wraps (count all-ones, enable=1, load=0), and 0 otherwise.
REQ-016: A load SHALL never assert wrap, even when loading zero from all-ones.
REQ-017: load_val SHALL be sampled only on the edge where load is high; changes to it at other times SHALL have no effect.
REQ-018: Inputs SHALL be treated as synchronous to clk; no internal synchronisers are required.
REQ-019: The block SHALL contain no other state and no handshake; every request SHALL be accepted on the edge it is present.

Reset
REQ-020: When rst_n goes low, count SHALL become 0 and wrap SHALL become 0 immediately, without waiting for a clock edge.
REQ-021: While rst_n is low, load and enable SHALL be ignored and the outputs SHALL stay at reset values.
REQ-022: A reset asserted mid-count SHALL discard the current value; after rst_n deasserts, the first edge SHALL apply normal rules starting from 0.
REQ-023: at_max SHALL be 0 during reset (count=0).

Verification
REQ-024: Assert rst_n=0 at t=0, release at 12 ns -> count=0, wrap=0, at_max=0 throughout reset.
REQ-025: Drive load=1, load_val=50, enable=0 for one edge -> count=50 after that edge; then enable=1 for 5 edges -> count=55.
REQ-026: Drive enable=0, load=0 for 3 edges -> count stays 55; then load=1, load_val=200 for one edge -> count=200.
REQ-027: Drive load=1, load_val=255 for one edge -> at_max=1; then enable=1 for one edge -> count=0, wrap=1 for one cycle, then 0.
REQ-028: Drive load=1, enable=1, load_val=10 together -> count=10 (not 11), wrap=0.
REQ-029: Assert rst_n=0 between clock edges while count=200 -> count=0 before the next edge; after release with enable=1 -> count=1 after the first edge.

Source files
------------

// File: rtl/smart_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smart_counter_if : request/status bundle for smart_counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface smart_counter_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             wrap;

   modport master (
      output enable, load, load_val,
      input  count, at_max, wrap
   );

   modport slave (
      input  enable, load, load_val,
      output count, at_max, wrap
   );
endinterface
`default_nettype wire

// File: rtl/smart_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// smart_counter : loadable wrapping up-counter with at_max flag and wrap pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module smart_counter #(
   parameter int WIDTH = 8
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   smart_counter_if.slave  bus
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q,  wrap_d;

   // Load takes priority over increment and never produces a wrap pulse.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = bus.load_val;
      end else if (bus.enable) begin
         count_d = count_q + WIDTH'(1);
         wrap_d  = (count_q == '1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.wrap   = wrap_q;
   assign bus.at_max = (count_q == '1);

endmodule
`default_nettype wire

// File: tb/tb_smart_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_smart_counter : vector table, reset corner sequences and random model check
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_smart_counter;
   localparam int WIDTH = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   smart_counter_if #(.WIDTH(WIDTH)) bus ();

   smart_counter #(.WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic       en;
      logic [7:0] lv;
      int         exp_cnt;
      logic       exp_wrap;
      logic       exp_max;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_outs(input string tag, input int c, input logic w, input logic m);
      check({tag, ".count"},  int'(bus.count),  c);
      check({tag, ".wrap"},   int'(bus.wrap),   int'(w));
      check({tag, ".at_max"}, int'(bus.at_max), int'(m));
   endtask

   task automatic cycle(input logic l, input logic e, input logic [7:0] v);
      bus.load     = l;
      bus.enable   = e;
      bus.load_val = v;
      @(posedge clk);
      #1;
   endtask

   int model_cnt;
   int exp_wrap;
   logic r_ld, r_en;
   logic [7:0] r_lv;

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n = 1'b0;
      bus.load = 1'b0; bus.enable = 1'b0; bus.load_val = '0;

      //             ld    en    lv   cnt wrap  max
      vecs[0]  = '{1'b1, 1'b0, 8'd50,  50, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'd0,   51, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'd0,   52, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 8'd0,   53, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 8'd0,   54, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 8'd0,   55, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'd9,   55, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'd9,   55, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'd9,   55, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 8'd200, 200, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 8'd255, 255, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 8'd0,   0,   1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'd0,   0,   1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 8'd10,  10,  1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 8'd255, 255, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 8'd0,   0,   1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 8'd123, 0,   1'b0, 1'b0};

      // Outputs must already be at reset values before any clock edge
      #2 check_outs("rst_t2", 0, 1'b0, 1'b0);
      bus.load = 1'b1; bus.enable = 1'b1; bus.load_val = 8'd77;
      #6 check_outs("rst_t8", 0, 1'b0, 1'b0);
      bus.load = 1'b0; bus.enable = 1'b0;
      #4 rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         cycle(vecs[i].ld, vecs[i].en, vecs[i].lv);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_wrap, vecs[i].exp_max);
      end

      // Async reset while count=200, then release with enable held
      cycle(1'b1, 1'b0, 8'd200);
      check("pre_rst.count", int'(bus.count), 200);
      bus.load = 1'b0; bus.enable = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_outs("async_rst", 0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_outs("held_rst", 0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_outs("post_rel", 1, 1'b0, 1'b0);

      // Async reset must clear an active wrap pulse immediately
      cycle(1'b1, 1'b0, 8'd255);
      cycle(1'b0, 1'b1, 8'd0);
      check_outs("wrap_pre", 0, 1'b1, 1'b0);
      bus.enable = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("wrap_rst.wrap", int'(bus.wrap), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomized traffic against a rule-level model
      model_cnt = 0;
      for (int k = 0; k < 400; k++) begin
         r_ld = ($urandom_range(0, 3) == 0);
         r_en = ($urandom_range(0, 1) == 1);
         r_lv = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom);
         exp_wrap = 0;
         if (r_ld) model_cnt = int'(r_lv);
         else if (r_en) begin
            if (model_cnt == MAXV) exp_wrap = 1;
            model_cnt = (model_cnt + 1) % (MAXV + 1);
         end
         cycle(r_ld, r_en, r_lv);
         check_outs($sformatf("rnd%0d", k), model_cnt, exp_wrap[0], model_cnt == MAXV);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end
endmodule
`default_nettype wire
